state_write: RTL and testbench

STATE_WRITE -- requirements
Module: state_write

---
 rtl/state_write.sv | 177 +++++++++++++++++
 tb/tb_state_write.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/state_write.sv
`default_nettype none
// ============================================================================
//  Module      : state_write
//  Description : Pixel-plot request buffer with a full-screen fill engine.
//                Requests are queued in a small FIFO and written one per
//                cycle. A fill request drains the queue first, then sweeps
//                every on-screen address with the captured fill colour.
//  Revision    : 1.0 - initial release
// ============================================================================
module state_write #(
    parameter int FIFO_DEPTH = 4,
    parameter int X_MAX      = 160,
    parameter int Y_MAX      = 120
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  x_in,
    input  logic [6:0]  y_in,
    input  logic [2:0]  color_in,
    input  logic        plot,
    output logic        ready,
    input  logic        fill,
    input  logic [2:0]  fill_color,
    output logic [14:0] address,
    output logic [2:0]  data,
    output logic        wren,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam int             CW       = AW + 1;
    localparam logic [CW-1:0]  C_FULL   = CW'(FIFO_DEPTH);
    localparam logic [8:0]     C_X_LIM  = 9'(X_MAX);
    localparam logic [7:0]     C_Y_LIM  = 8'(Y_MAX);
    localparam logic [7:0]     C_X_LAST = 8'(X_MAX - 1);
    localparam logic [6:0]     C_Y_LAST = 7'(Y_MAX - 1);

    state_t          r_state;
    logic            r_fill_pending;
    logic [2:0]      r_fill_col;
    logic [7:0]      r_fx;
    logic [6:0]      r_fy;

    logic [17:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_in_range;
    logic            w_push;
    logic            w_pop;
    logic [17:0]     w_head;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_FULL);
    assign w_in_range = ({1'b0, x_in} < C_X_LIM) && ({1'b0, y_in} < C_Y_LIM);
    // Out-of-range requests are still accepted, they just never enter the queue.
    assign w_push     = plot && ready && w_in_range;
    assign w_pop      = ((r_state == S_IDLE) || (r_state == S_DRAIN)) && !w_empty;
    assign w_head     = r_mem[r_rd_ptr];

    // ready depends on registered state only, never on plot.
    assign ready = ((r_state == S_IDLE) || (r_state == S_DRAIN)) && !r_fill_pending && !w_full;
    assign busy  = (r_state == S_DRAIN) || (r_state == S_FILL);

    // FIFO storage; no reset needed since occupancy is tracked by r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {x_in, y_in, color_in};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Control FSM with registered memory-side outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_fill_pending <= 1'b0;
            r_fill_col     <= 3'd0;
            r_fx           <= 8'd0;
            r_fy           <= 7'd0;
            address        <= 15'd0;
            data           <= 3'd0;
            wren           <= 1'b0;
            done           <= 1'b0;
        end else begin
            wren <= 1'b0;
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (fill && !r_fill_pending) begin
                        r_fill_pending <= 1'b1;
                        r_fill_col     <= fill_color;
                    end
                    if (w_pop) begin
                        address <= {w_head[17:10], w_head[9:3]};
                        data    <= w_head[2:0];
                        wren    <= 1'b1;
                    end
                    if (r_fill_pending) begin
                        if (!w_empty) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state        <= S_FILL;
                            r_fill_pending <= 1'b0;
                            r_fx           <= 8'd0;
                            r_fy           <= 7'd0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop) begin
                        address <= {w_head[17:10], w_head[9:3]};
                        data    <= w_head[2:0];
                        wren    <= 1'b1;
                    end else begin
                        r_state        <= S_FILL;
                        r_fill_pending <= 1'b0;
                        r_fx           <= 8'd0;
                        r_fy           <= 7'd0;
                    end
                end
                S_FILL: begin
                    // y is the inner loop; counters stop at the last pixel.
                    address <= {r_fx, r_fy};
                    data    <= r_fill_col;
                    wren    <= 1'b1;
                    if (r_fy == C_Y_LAST) begin
                        r_fy <= 7'd0;
                        if (r_fx == C_X_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_fx <= r_fx + 8'd1;
                        end
                    end else begin
                        r_fy <= r_fy + 7'd1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_state_write.sv
`default_nettype none
// ============================================================================
//  Module      : tb_state_write
//  Description : Directed self-checking bench for state_write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_state_write;

    logic        clock = 1'b0;
    logic        resetn;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [2:0]  color_in;
    logic        plot;
    logic        ready;
    logic        fill;
    logic [2:0]  fill_color;
    logic [14:0] address;
    logic [2:0]  data;
    logic        wren;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [17:0] wq[$];
    int          done_cnt = 0;

    state_write #(.FIFO_DEPTH(4), .X_MAX(160), .Y_MAX(120)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .x_in       (x_in),
        .y_in       (y_in),
        .color_in   (color_in),
        .plot       (plot),
        .ready      (ready),
        .fill       (fill),
        .fill_color (fill_color),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Record every write and done pulse away from the active edge.
    always @(negedge clock) begin
        if (wren) wq.push_back({address, data});
        if (done) done_cnt++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0; plot = 1'b0; fill = 1'b0;
        x_in = '0; y_in = '0; color_in = '0; fill_color = '0;
        repeat (2) tick;
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", wren); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (address !== 15'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", address); end
        total++; if (data !== 3'b0) begin bad++; $display("FAIL reset_data: got %b want 0", data); end
        resetn = 1'b1;
        tick;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    endtask

    task automatic test_single;
        wq.delete();
        x_in = 8'd5; y_in = 7'd7; color_in = 3'b101; plot = 1'b1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", ready); end
        tick;
        plot = 1'b0;
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL single_early: got wren=%b want 0", wren); end
        tick;
        total++; if (wren !== 1'b1) begin bad++; $display("FAIL single_wren: got %b want 1", wren); end
        total++; if (address !== 15'h0287) begin bad++; $display("FAIL single_addr: got %h want 0287", address); end
        total++; if (data !== 3'b101) begin bad++; $display("FAIL single_data: got %b want 101", data); end
        tick;
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL single_oneshot: got wren=%b want 0", wren); end
        total++; if (address !== 15'h0287) begin bad++; $display("FAIL single_hold: got %h want 0287", address); end
        total++; if (wq.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", wq.size()); end
    endtask

    task automatic test_back_to_back;
        logic [17:0] exp;
        wq.delete();
        for (int i = 0; i < 5; i++) begin
            x_in = 8'(10 + i); y_in = 7'(20 + i); color_in = 3'(i + 1); plot = 1'b1;
            total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, ready); end
            tick;
        end
        plot = 1'b0;
        repeat (4) tick;
        total++; if (wq.size() !== 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", wq.size()); end
        for (int i = 0; i < 5; i++) begin
            exp = {8'(10 + i), 7'(20 + i), 3'(i + 1)};
            if (wq.size() > i) begin
                total++; if (wq[i] !== exp) begin bad++; $display("FAIL b2b_write%0d: got %h want %h", i, wq[i], exp); end
            end
        end
    endtask

    task automatic test_out_of_range;
        wq.delete();
        x_in = 8'd160; y_in = 7'd0; color_in = 3'b111; plot = 1'b1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL oor_ready_x: got %b want 1", ready); end
        tick;
        x_in = 8'd0; y_in = 7'd120;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL oor_ready_y: got %b want 1", ready); end
        tick;
        plot = 1'b0;
        repeat (5) tick;
        total++; if (wq.size() !== 0) begin bad++; $display("FAIL oor_writes: got %0d want 0", wq.size()); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL oor_ready_after: got %b want 1", ready); end
    endtask

    task automatic test_fill_queued;
        int          n;
        int          dc0;
        int          first_bad;
        bit          rdy_seen;
        logic        busy_mid;
        logic [17:0] exp;
        wq.delete();
        dc0 = done_cnt; rdy_seen = 1'b0; busy_mid = 1'b0; first_bad = -1;
        for (int i = 0; i < 3; i++) begin
            x_in = 8'(1 + i); y_in = 7'(2 + i); color_in = 3'(4 + i); plot = 1'b1;
            if (i == 2) begin fill = 1'b1; fill_color = 3'b010; end
            tick;
        end
        plot = 1'b0; fill = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL fill_ready_latched: got %b want 0", ready); end
        n = 0;
        while (!done && n < 20000) begin
            if (ready) rdy_seen = 1'b1;
            if (n == 50) busy_mid = busy;
            if (n == 100) begin fill = 1'b1; fill_color = 3'b111; end else fill = 1'b0;
            tick;
            n++;
        end
        fill = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL fill_done_timeout: got done=%b want 1", done); end
        total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL fill_ready_during: got %b want 0", rdy_seen); end
        total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL fill_busy: got %b want 1", busy_mid); end
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL fill_done_wren: got %b want 0", wren); end
        tick;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL fill_done_pulse: got %b want 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fill_busy_after: got %b want 0", busy); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL fill_ready_after: got %b want 1", ready); end
        total++; if (wq.size() !== 19203) begin bad++; $display("FAIL fill_count: got %0d want 19203", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            exp = {8'(1 + i), 7'(2 + i), 3'(4 + i)};
            if (wq.size() > i) begin
                total++; if (wq[i] !== exp) begin bad++; $display("FAIL fill_pixel%0d: got %h want %h", i, wq[i], exp); end
            end
        end
        for (int j = 0; j < 19200; j++) begin
            exp = {8'(j / 120), 7'(j % 120), 3'b010};
            if (first_bad < 0 && (wq.size() <= j + 3 || wq[j + 3] !== exp)) first_bad = j;
        end
        total++; if (first_bad >= 0) begin bad++; $display("FAIL fill_sweep: first wrong write at index %0d, want %h", first_bad, {8'(first_bad / 120), 7'(first_bad % 120), 3'b010}); end
        total++; if (done_cnt - dc0 !== 1) begin bad++; $display("FAIL fill_done_count: got %0d want 1", done_cnt - dc0); end
        repeat (5) tick;
        total++; if (wq.size() !== 19203) begin bad++; $display("FAIL fill_ignored: got %0d writes want 19203", wq.size()); end
    endtask

    task automatic test_reset_mid_fill;
        int n;
        int sz;
        int dc;
        wq.delete();
        fill = 1'b1; fill_color = 3'b011;
        tick;
        fill = 1'b0;
        n = 0;
        while (wq.size() < 1000 && n < 1200) begin tick; n++; end
        total++; if (wq.size() < 1000) begin bad++; $display("FAIL rst_fill_timeout: got %0d writes want 1000", wq.size()); end
        total++; if (wq.size() == 0 || wq[0] !== {15'h0, 3'b011}) begin bad++; $display("FAIL rst_fill_first: got %h want 00003", (wq.size() > 0) ? wq[0] : 18'h3ffff); end
        resetn = 1'b0;
        #1;
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL rst_async_wren: got %b want 0", wren); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        total++; if (address !== 15'h0) begin bad++; $display("FAIL rst_async_addr: got %h want 0", address); end
        sz = wq.size(); dc = done_cnt;
        tick; tick;
        resetn = 1'b1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready_release: got %b want 1", ready); end
        repeat (30) tick;
        total++; if (done_cnt !== dc) begin bad++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - dc); end
        total++; if (wq.size() !== sz) begin bad++; $display("FAIL rst_no_writes: got %0d writes want 0", wq.size() - sz); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_range();
        test_fill_queued();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
